rr_grant_ctrl: RTL and testbench
================================

# rr_grant_ctrl

Round-robin arbiter and hold-time scheduler that shares one single-ported resource (register bank, heap memory port) among N requesters. It samples a request vector and issues a registered one-hot grant. The grant is held until the owner releases it or a maximum hold time expires, and the block rotates priority so every persistent requester is served within N grants. It sits between the requesting lab datapaths and the shared resource's enable/select lines.

## Interface
- N, default 4: number of requesters (2..16).
- MAX_HOLD, default 8: maximum consecutive cycles a grant is held (≥1).
- clk, input, 1: single clock; all state changes on posedge.
- clr, input, 1: synchronous, active-high reset, sampled on posedge clk; highest priority over every other input.
- req, input, N: request vector; bit i high = requester i wants the resource.
- done, input, 1: release strobe from the current owner.
- grant, output, N: registered one-hot grant; all zeros when no owner.
- gnt_id, output, $clog2(N): index of the current owner; 0 when no owner.
- busy, output, 1: high while any grant bit is high.
- timeout, output, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- States: IDLE, GRANT, GAP. Internal registers: ptr ($clog2(N) bits, priority start) and hold_cnt ($clog2(MAX_HOLD+1) bits).
- Reset (clr=1): state=IDLE, grant=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0. This applies in any state, including mid-grant.
- IDLE, req=0: stay in IDLE; outputs stay zero.
- IDLE, req≠0: the winner is the first set bit scanning ptr, ptr+1, … wrapping modulo N. On the edge:
  - state=GRANT, grant=onehot(winner), gnt_id=winner, busy=1;
  - ptr=(winner+1) mod N, wrapping N-1→0;
  - hold_cnt=0.
- GRANT: hold_cnt increments each cycle. A release condition is done=1, or req[gnt_id]=0 (owner withdrew).
  - On release: next state is GAP.
  - Otherwise, if hold_cnt==MAX_HOLD-1: next state is GAP and timeout=1 for the following cycle.
  - Otherwise: stay in GRANT.
- Release and the hold-limit reached in the same cycle: treat as a normal release; timeout stays 0.
- GAP: grant=0, gnt_id=0, busy=0 for one cycle, then IDLE unconditionally. timeout is high only during this GAP cycle when it was a forced revoke.
- Changes to req bits other than the owner's, while in GRANT, are ignored.
- done in IDLE or GAP is ignored.

## Timing
- Grant latency: a request seen in IDLE at cycle t gives grant at cycle t+1.
- Maximum hold: grant is high for at most MAX_HOLD consecutive cycles. Minimum hold is 1 cycle (done in the first grant cycle).
- Release at cycle t (done sampled high) gives grant=0 at t+1 (GAP) and IDLE at t+2. The earliest next grant is at t+3.
- Worst-case wait for a continuously requesting input: (N-1)·(MAX_HOLD+2) cycles plus the arbitration cycle.
- All outputs are registered; there are no combinational paths from req/done to grant.

## Structure
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2;
  - width helpers: ID_W=$clog2(N), CNT_W=$clog2(MAX_HOLD+1).
- One sub-module, rr_pick: a purely combinational rotate-and-priority-encode. It takes req and ptr and returns the winner index and a valid flag. The top level contains the FSM, counter and output registers.
- Target size 150–250 lines of RTL.

## Test plan
Settings for all scenarios: N=4, MAX_HOLD=8.
- Reset then req=4'b0101, done low: grant=4'b0001 and gnt_id=0 one cycle later. Pulse done after 3 grant cycles: grant=0 for one GAP cycle. Next grant is 4'b0100 and ptr=3.
- req=4'b1111 held, done pulsed in every grant's 2nd cycle: grants follow 0001, 0010, 0100, 1000, 0001, each separated by exactly 2 zero cycles (GAP and IDLE); wrap-around is checked.
- req=4'b0010 held, done never asserted: grant high exactly 8 cycles, then timeout=1 for one cycle with grant=0. The same requester is re-granted two cycles after revoke.
- done=1 on the 8th grant cycle (hold limit reached): grant drops with timeout=0.
- clr=1 during the 4th cycle of a grant to requester 2: grant=0, busy=0 and ptr=0 on the next edge. With req=4'b1010 afterwards, the first grant is 4'b0010.
- Owner requester 1 drops req[1] mid-grant while req[3]=1: this is treated as a release. GAP follows, then grant=4'b1000, and timeout stays 0 throughout.

Source files
------------

// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and width helpers for the round-robin grant controller.
package rr_grant_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Owner index width; kept at least 1 bit so ports never collapse.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode: first set req bit at or after ptr.
module rr_pick
    import rr_grant_ctrl_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win_c,
    output logic            valid_c
);

    logic [ID_W-1:0] idx;

    always_comb begin
        win_c   = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ID_W'((32'(ptr) + k) % N);
            if (!valid_c && req[idx]) begin
                win_c   = idx;
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with bounded hold time and a one-cycle gap between owners.
module rr_grant_ctrl
    import rr_grant_ctrl_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned ID_W     = id_w(N),
    localparam int unsigned CNT_W    = cnt_w(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0] win_c;
    logic            valid_c;
    logic            release_c;
    logic            limit_c;
    logic [ID_W-1:0] ptr_next_c;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_c   (win_c),
        .valid_c (valid_c)
    );

    // Owner releases by strobing done or by dropping its own request.
    assign release_c  = done | ~req[gnt_id];
    assign limit_c    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign ptr_next_c = (win_c == ID_W'(N - 1)) ? '0 : win_c + ID_W'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            grant    <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (valid_c) begin
                        state    <= ST_GRANT;
                        grant    <= N'(1) << win_c;
                        gnt_id   <= win_c;
                        busy     <= 1'b1;
                        ptr      <= ptr_next_c;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_c || limit_c) begin
                        state   <= ST_GAP;
                        grant   <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        // A voluntary release wins over a coincident hold limit.
                        timeout <= ~release_c;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed scenarios plus randomized run against a reference model.
module tb_rr_grant_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         done;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner index (-1 = none), completed hold cycles, gap flag.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        if (clr) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_gap   = 1'b0;
            m_to    = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (done || !req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (req[c]) begin
                    m_owner = c;
                    m_held  = 0;
                    m_ptr   = (c + 1) % N;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [N+3:0] model_out();
        logic [N-1:0] g;
        logic [1:0]   id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g  = N'(1) << m_owner;
            id = 2'(m_owner);
        end
        return {g, id, (m_owner >= 0), m_to};
    endfunction

    // Advance one clock; model consumes the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        clr  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        tick();
        tick();
        vectors++;
        if ({grant, gnt_id, busy, timeout} !== 8'h00 || dut.ptr !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: grant=%b id=%0d busy=%b to=%b ptr=%0d, want all zero",
                     grant, gnt_id, busy, timeout, dut.ptr);
        end
        clr = 1'b0;
        req = '0;
    endtask

    task automatic test_basic();
        go_idle();
        req = 4'b0101;
        tick();
        vectors++;
        if (grant !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first: grant=%b id=%0d busy=%b, want 0001 0 1", grant, gnt_id, busy);
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gap: grant=%b busy=%b to=%b, want 0000 0 0", grant, busy, timeout);
        end
        tick();
        tick();
        vectors++;
        if (grant !== 4'b0100 || gnt_id !== 2'd2 || dut.ptr !== 2'd3) begin
            miscompares++;
            $display("FAIL basic_second: grant=%b id=%0d ptr=%0d, want 0100 2 3", grant, gnt_id, dut.ptr);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        go_idle();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (grant !== exp_seq[k]) begin
                miscompares++;
                $display("FAIL rotation_%0d: grant=%b, want %b", k, grant, exp_seq[k]);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            vectors++;
            if (grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL rotation_gap_%0d: grant=%b, want 0000", k, grant);
            end
            tick();
            vectors++;
            if (grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL rotation_idle_%0d: grant=%b, want 0000", k, grant);
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        go_idle();
        req = 4'b0010;
        tick();
        cnt = 0;
        while (grant === 4'b0010 && cnt < 20) begin
            cnt++;
            tick();
        end
        vectors++;
        if (cnt != MAX_HOLD || grant !== 4'b0000 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_revoke: held=%0d grant=%b to=%b, want 8 0000 1", cnt, grant, timeout);
        end
        tick();
        vectors++;
        if (timeout !== 1'b0 || grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL timeout_pulse: to=%b grant=%b, want 0 0000", timeout, grant);
        end
        tick();
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_regrant: grant=%b, want 0010", grant);
        end
    endtask

    task automatic test_done_at_limit();
        go_idle();
        req = 4'b0010;
        tick();
        for (int k = 0; k < MAX_HOLD - 1; k++) tick();
        vectors++;
        if (grant !== 4'b0010) begin
            miscompares++;
            $display("FAIL limit_held: grant=%b, want 0010", grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        vectors++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_release: grant=%b to=%b, want 0000 0", grant, timeout);
        end
    endtask

    task automatic test_clr_mid_grant();
        go_idle();
        req = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0 || dut.ptr !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_mid: grant=%b busy=%b ptr=%0d, want 0000 0 0", grant, busy, dut.ptr);
        end
        req = 4'b1010;
        tick();
        vectors++;
        if (grant !== 4'b0010 || gnt_id !== 2'd1) begin
            miscompares++;
            $display("FAIL clr_after: grant=%b id=%0d, want 0010 1", grant, gnt_id);
        end
    endtask

    task automatic test_withdraw();
        go_idle();
        req = 4'b1010;
        tick();
        tick();
        req = 4'b1000;
        tick();
        vectors++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_gap: grant=%b to=%b, want 0000 0", grant, timeout);
        end
        tick();
        tick();
        vectors++;
        if (grant !== 4'b1000 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_next: grant=%b to=%b, want 1000 0", grant, timeout);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int k = 0; k < 3000; k++) begin
            req  = N'($urandom);
            done = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if ({grant, gnt_id, busy, timeout} !== model_out() || dut.ptr !== 2'(m_ptr)) begin
                miscompares++;
                $display("FAIL random_%0d: dut=%b ptr=%0d, model=%b ptr=%0d",
                         k, {grant, gnt_id, busy, timeout}, dut.ptr, model_out(), m_ptr);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        clr  = 1'b1;
        req  = '0;
        done = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_done_at_limit();
        test_clr_mid_grant();
        test_withdraw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
